mask_encoder: RTL and testbench

Run-length encoder that converts a raster stream of per-pixel segment IDs into 40-bit segment mask records. Records are emitted as a 16-bit ioctl download stream, byte-exact with the format the segment mask loader consumes. It sits between the simulation/self-test pixel source and the ioctl bus, and regenerates mask images for loopback verification of the mask path.

---
 rtl/mask_encoder.sv | 235 +++++++++++++++++++++++
 tb/tb_mask_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_encoder.sv
// mask_encoder: run-length encoder for per-pixel segment IDs.
// Runs become 40-bit records, sent LSB-first as 16-bit ioctl words.
module mask_encoder #(
  parameter logic [24:0] START_ADDRESS = 25'h17BB00,
  parameter int          WR_GAP        = 4,
  parameter int          FIFO_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [9:0]  video_x,
  input  logic [9:0]  video_y,
  input  logic        pixel_on,
  input  logic [9:0]  pixel_id,
  input  logic        frame_end,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [15:0] ioctl_dout,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(WR_GAP + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [GW-1:0] gap_t;

  localparam cnt_t DEPTH_C    = cnt_t'(FIFO_DEPTH);
  localparam gap_t GAP_RELOAD = gap_t'(WR_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, WAIT_GAP, FLUSH, DONE
  } state_t;

  logic        open;
  logic [9:0]  run_x, run_y, run_id, run_len;
  logic        ext, c0_v, c1_v, n_open;
  logic [9:0]  n_x, n_y, n_id, n_len;
  logic        rec0_v, rec1_v, fe_d;
  logic [39:0] rec0, rec1;

  always_comb begin
    ext = pixel_valid && open && pixel_on
       && (pixel_id == run_id)
       && (video_y == run_y)
       && (video_x == run_x + run_len)
       && (run_len != 10'd1023);
    n_open = open;
    n_x    = run_x;
    n_y    = run_y;
    n_id   = run_id;
    n_len  = run_len;
    c0_v   = 1'b0;
    if (pixel_valid) begin
      if (ext) begin
        n_len = run_len + 10'd1;
      end else begin
        c0_v   = open;
        n_open = pixel_on;
        if (pixel_on) begin
          n_x   = video_x;
          n_y   = video_y;
          n_id  = pixel_id;
          n_len = 10'd1;
        end
      end
    end
    // frame_end closes whatever run the current pixel left open
    c1_v = frame_end && n_open;
    if (frame_end) n_open = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      open    <= 1'b0;
      run_x   <= '0;
      run_y   <= '0;
      run_id  <= '0;
      run_len <= '0;
      rec0_v  <= 1'b0;
      rec1_v  <= 1'b0;
      rec0    <= '0;
      rec1    <= '0;
      fe_d    <= 1'b0;
    end else begin
      open    <= n_open;
      run_x   <= n_x;
      run_y   <= n_y;
      run_id  <= n_id;
      run_len <= n_len;
      rec0_v  <= c0_v;
      rec0    <= {run_len, run_y, run_x, run_id};
      rec1_v  <= c1_v;
      rec1    <= {n_len, n_y, n_x, n_id};
      fe_d    <= frame_end;
    end
  end

  logic [39:0] mem [FIFO_DEPTH];
  ptr_t        wptr, rptr;
  cnt_t        cnt, used1;
  logic        w0, w1, drop, do_pop;

  always_comb begin
    w0    = rec0_v && (cnt != DEPTH_C);
    used1 = cnt + cnt_t'(w0);
    w1    = rec1_v && (used1 != DEPTH_C);
    drop  = (rec0_v && !w0) || (rec1_v && !w1);
  end

  always_ff @(posedge clk) begin
    if (w0) mem[wptr] <= rec0;
    if (w1) mem[wptr + ptr_t'(w0)] <= rec1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr + ptr_t'(w0) + ptr_t'(w1);
      rptr <= rptr + ptr_t'(do_pop);
      cnt  <= used1 + cnt_t'(w1) - cnt_t'(do_pop);
      if (drop) overflow <= 1'b1;
    end
  end

  state_t      state, state_n, after;
  logic [39:0] shreg;
  logic [2:0]  bcnt;
  logic [15:0] word;
  logic        half, armed;
  gap_t        gap;
  logic [24:0] wr_addr;
  logic        do_shift, do_wr, do_done;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_pop   = 1'b0;
    do_shift = 1'b0;
    do_wr    = 1'b0;
    do_done  = 1'b0;
    after    = (cnt != '0) ? LOAD : (armed ? FLUSH : IDLE);
    unique case (state)
      IDLE: state_n = after;
      LOAD: begin
        do_pop  = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (half)              state_n = WAIT_GAP;
        else if (bcnt == 3'd1) state_n = after;
      end
      WAIT_GAP: begin
        if (gap == '0) begin
          do_wr   = 1'b1;
          state_n = (bcnt != 3'd0) ? SHIFT : after;
        end
      end
      FLUSH: begin
        if (!half) begin
          state_n = DONE;
        end else if (gap == '0) begin
          do_wr   = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        do_done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bcnt       <= '0;
      word       <= '0;
      half       <= 1'b0;
      gap        <= '0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ioctl_wr   <= 1'b0;
      ioctl_dout <= '0;
      ioctl_addr <= START_ADDRESS;
      wr_addr    <= START_ADDRESS;
    end else begin
      ioctl_wr <= do_wr;
      done     <= do_done;
      if (do_wr)           gap <= GAP_RELOAD;
      else if (gap != '0)  gap <= gap - gap_t'(1);
      if (do_pop) begin
        shreg <= mem[rptr];
        bcnt  <= 3'd5;
      end
      if (do_shift) begin
        shreg <= shreg >> 8;
        bcnt  <= bcnt - 3'd1;
        if (half) word[15:8] <= shreg[7:0];
        else      word[7:0]  <= shreg[7:0];
        half <= !half;
      end
      if (do_wr) begin
        // a lone low byte only reaches the bus on flush, padded with zero
        ioctl_dout <= half ? {8'h00, word[7:0]} : word;
        ioctl_addr <= wr_addr;
        wr_addr    <= wr_addr + 25'd2;
        half       <= 1'b0;
      end
      if (fe_d)         armed <= 1'b1;
      else if (do_done) armed <= 1'b0;
      if (pixel_valid)  busy <= 1'b1;
      else if (do_done) busy <= 1'b0;
      if (do_done) begin
        wr_addr    <= START_ADDRESS;
        ioctl_addr <= START_ADDRESS;
      end
    end
  end

endmodule

// File: tb/tb_mask_encoder.sv
// tb_mask_encoder: directed frames, byte stream decoded back into records.
// Checks addresses, write spacing, padding, overflow and reset behaviour.
module tb_mask_encoder;

  localparam logic [24:0] START = 25'h17BB00;
  localparam int          GAP   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_valid = 1'b0;
  logic [9:0]  video_x = '0;
  logic [9:0]  video_y = '0;
  logic        pixel_on = 1'b0;
  logic [9:0]  pixel_id = '0;
  logic        frame_end = 1'b0;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        busy, done, overflow;

  always #5 clk = ~clk;

  mask_encoder #(
    .START_ADDRESS(START),
    .WR_GAP(GAP),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pixel_valid(pixel_valid),
    .video_x(video_x),
    .video_y(video_y),
    .pixel_on(pixel_on),
    .pixel_id(pixel_id),
    .frame_end(frame_end),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  typedef struct packed {
    logic [9:0]  y;
    logic [9:0]  x0;
    logic [10:0] n;
    logic        on;
    logic [9:0]  id;
  } seg_t;

  typedef struct packed {
    seg_t [2:0]        seg;
    logic [1:0]        nseg;
    logic [2:0][39:0]  exp;
    logic [1:0]        nexp;
  } case_t;

  int          pass_cnt = 0;
  int          total = 0;
  int          cyc = 0;
  int          last_wr = -1000;
  logic [24:0] exp_addr = START;
  logic [7:0]  bq[$];
  case_t       cases[6];

  function automatic logic [39:0] rec(input int len, input int y,
                                      input int x, input int id);
    return {10'(len), 10'(y), 10'(x), 10'(id)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (ioctl_wr) begin
      chk("wr_addr", 64'(ioctl_addr), 64'(exp_addr));
      chk("wr_spacing", 64'(cyc - last_wr >= GAP), 64'd1);
      exp_addr = exp_addr + 25'd2;
      last_wr  = cyc;
      bq.push_back(ioctl_dout[7:0]);
      bq.push_back(ioctl_dout[15:8]);
    end
  end

  task automatic pix(input logic v, input logic [9:0] x, input logic [9:0] y,
                     input logic on, input logic [9:0] id, input logic fe);
    @(negedge clk);
    pixel_valid = v;
    video_x     = x;
    video_y     = y;
    pixel_on    = on;
    pixel_id    = id;
    frame_end   = fe;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pixel_valid = 1'b0;
    frame_end = 1'b0;
    last_wr = -1000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_addr = START;
    bq.delete();
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 64'(got), 64'd1);
  endtask

  task automatic wait_and_check(input logic [2:0][39:0] exp,
                                input int nexp, input string tag);
    logic [39:0] r;
    int nb;
    wait_done(tag);
    nb = ((5 * nexp + 1) / 2) * 2;
    chk({tag, "_bytes"}, 64'(bq.size()), 64'(nb));
    for (int k = 0; k < nexp; k++) begin
      if (bq.size() >= 5 * k + 5) begin
        r = {bq[5*k+4], bq[5*k+3], bq[5*k+2], bq[5*k+1], bq[5*k]};
        chk($sformatf("%s_rec%0d", tag, k), 64'(r), 64'(exp[k]));
      end
    end
    if ((nexp % 2) == 1 && bq.size() == nb)
      chk({tag, "_pad"}, 64'(bq[nb-1]), 64'd0);
    chk({tag, "_busy_clr"}, 64'(busy), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  task automatic run_case(input int c);
    case_t cc;
    seg_t  sg;
    cc = cases[c];
    bq.delete();
    exp_addr = START;
    for (int s = 0; s < int'(cc.nseg); s++) begin
      sg = cc.seg[s];
      for (int i = 0; i < int'(sg.n); i++)
        pix(1'b1, sg.x0 + 10'(i), sg.y, sg.on, sg.id, 1'b0);
    end
    pix(1'b0, '0, '0, 1'b0, '0, 1'b1);
    chk($sformatf("case%0d_busy", c), 64'(busy), 64'd1);
    pix(1'b0, '0, '0, 1'b0, '0, 1'b0);
    wait_and_check(cc.exp, int'(cc.nexp), $sformatf("case%0d", c));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [2:0][39:0] ex;
    logic [39:0] r;
    bit seen;

    for (int i = 0; i < 6; i++) cases[i] = '0;
    cases[0].seg[0] = '{10'd5, 10'd10, 11'd4, 1'b1, 10'd7};
    cases[0].nseg   = 2'd1;
    cases[0].exp[0] = rec(4, 5, 10, 7);
    cases[0].nexp   = 2'd1;
    cases[1].seg[0] = '{10'd0, 10'd0, 11'd2, 1'b1, 10'd1};
    cases[1].seg[1] = '{10'd0, 10'd2, 11'd3, 1'b1, 10'd2};
    cases[1].nseg   = 2'd2;
    cases[1].exp[0] = rec(2, 0, 0, 1);
    cases[1].exp[1] = rec(3, 0, 2, 2);
    cases[1].nexp   = 2'd2;
    cases[2].seg[0] = '{10'd3, 10'd0, 11'd2, 1'b1, 10'd4};
    cases[2].seg[1] = '{10'd3, 10'd2, 11'd3, 1'b0, 10'd4};
    cases[2].seg[2] = '{10'd3, 10'd5, 11'd1, 1'b1, 10'd4};
    cases[2].nseg   = 2'd3;
    cases[2].exp[0] = rec(2, 3, 0, 4);
    cases[2].exp[1] = rec(1, 3, 5, 4);
    cases[2].nexp   = 2'd2;
    cases[3].seg[0] = '{10'd8, 10'd100, 11'd2, 1'b1, 10'd9};
    cases[3].seg[1] = '{10'd9, 10'd102, 11'd2, 1'b1, 10'd9};
    cases[3].nseg   = 2'd2;
    cases[3].exp[0] = rec(2, 8, 100, 9);
    cases[3].exp[1] = rec(2, 9, 102, 9);
    cases[3].nexp   = 2'd2;
    cases[4].seg[0] = '{10'd1, 10'd0, 11'd1030, 1'b1, 10'd3};
    cases[4].nseg   = 2'd1;
    cases[4].exp[0] = rec(1023, 1, 0, 3);
    cases[4].exp[1] = rec(7, 1, 1023, 3);
    cases[4].nexp   = 2'd2;
    cases[5].seg[0] = '{10'd2, 10'd0, 11'd5, 1'b0, 10'd0};
    cases[5].nseg   = 2'd1;
    cases[5].nexp   = 2'd0;

    repeat (3) @(negedge clk);
    chk("rst_wr", 64'(ioctl_wr), 64'd0);
    chk("rst_addr", 64'(ioctl_addr), 64'(START));
    chk("rst_dout", 64'(ioctl_dout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;

    for (int c = 0; c < 6; c++) run_case(c);

    // pixel sharing its cycle with frame_end: pixel first, then close
    bq.delete();
    exp_addr = START;
    for (int i = 0; i < 3; i++)
      pix(1'b1, 10'(i), 10'd2, 1'b1, 10'd5, 1'b0);
    pix(1'b1, 10'd3, 10'd2, 1'b1, 10'd6, 1'b1);
    pix(1'b0, '0, '0, 1'b0, '0, 1'b0);
    ex = '0;
    ex[0] = rec(3, 2, 0, 5);
    ex[1] = rec(1, 2, 3, 6);
    wait_and_check(ex, 2, "fe_pix");

    // burst of isolated pixels outruns the serializer
    bq.delete();
    exp_addr = START;
    for (int i = 0; i < 40; i++) begin
      if (i == 16) chk("ovf_early", 64'(overflow), 64'd0);
      pix(1'b1, 10'(2 * i), 10'd4, 1'b1, 10'd1, 1'b0);
    end
    pix(1'b0, '0, '0, 1'b0, '0, 1'b1);
    pix(1'b0, '0, '0, 1'b0, '0, 1'b0);
    wait_done("ovf");
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_nbytes_ge5", 64'(bq.size() >= 5), 64'd1);
    if (bq.size() >= 5) begin
      r = {bq[4], bq[3], bq[2], bq[1], bq[0]};
      chk("ovf_rec0", 64'(r), 64'(rec(1, 4, 0, 1)));
    end
    do_reset();
    chk("ovf_clr", 64'(overflow), 64'd0);

    // reset while a word is waiting on the gap counter
    for (int i = 0; i < 4; i++)
      pix(1'b1, 10'(10 + i), 10'd5, 1'b1, 10'd7, 1'b0);
    pix(1'b0, '0, '0, 1'b0, '0, 1'b1);
    pix(1'b0, '0, '0, 1'b0, '0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ioctl_wr) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_first_wr", 64'(seen), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_wr", 64'(ioctl_wr), 64'd0);
    chk("mid_addr", 64'(ioctl_addr), 64'(START));
    chk("mid_dout", 64'(ioctl_dout), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    bq.delete();
    exp_addr = START;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("mid_no_wr", 64'(bq.size()), 64'd0);
    chk("mid_no_done", 64'(seen), 64'd0);

    run_case(0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
